// File: rtl/bgr_ctrl_pkg.sv
// Shared types and helpers for the background-removal stream controller.
// Holds the sequencer state encoding, default widths and a saturating
// increment used by every counter in the block.
package bgr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int NF_W_DEF   = 16;
  localparam int WDOG_W_DEF = 24;
  localparam int PERF_W_DEF = 32;

  // Counters up to this width share the helper below; callers widen/narrow.
  localparam int SAT_W = 32;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] value,
                                               input logic [SAT_W-1:0] max_val);
    if (value >= max_val) begin
      return max_val;
    end
    return value + SAT_W'(1);
  endfunction

endpackage

// File: rtl/bgr_wdog.sv
// No-progress watchdog for the background-removal kernel.
// Counts consecutive enabled cycles without progress and flags expiry on the
// cycle whose count reaches a non-zero limit. The count saturates and holds
// whenever the watchdog is disabled.
module bgr_wdog
  import bgr_ctrl_pkg::*;
#(
  parameter int W = WDOG_W_DEF
) (
  input  logic         ap_clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         progress,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Next count: clear wins, progress resets, otherwise saturating increment.
  always_comb begin
    cnt_next = cnt_reg;
    if (clear) begin
      cnt_next = '0;
    end else if (enable) begin
      if (progress) begin
        cnt_next = '0;
      end else begin
        cnt_next = W'(sat_inc(SAT_W'(cnt_reg), SAT_W'(CNT_MAX)));
      end
    end
  end

  // Expiry is taken from the incremented value so the fault lands on the same
  // edge at which the count reaches the limit.
  assign expired = enable && !clear && !progress && (limit != '0) && (cnt_next == limit);

  // Counter register.
  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/bgr_stream_ctrl.sv
// Frame sequencer and watchdog for the background-removal AXI-Stream kernel.
// Drives ap_ctrl_hs for a programmed number of frames, counts completed
// frames and faults when the pipeline stops making progress.
// Optional macro BGR_CTRL_PERF_EN enables the stall and frame-length counters;
// without it those outputs read zero.
module bgr_stream_ctrl
  import bgr_ctrl_pkg::*;
#(
  parameter int NF_W   = NF_W_DEF,
  parameter int WDOG_W = WDOG_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [NF_W-1:0]   cfg_num_frames,
  input  logic [WDOG_W-1:0] cfg_wdog_limit,
  output logic              kern_ap_start,
  input  logic              kern_ap_ready,
  input  logic              kern_ap_done,
  input  logic              in_tvalid,
  input  logic              in_tready,
  input  logic              out_tvalid,
  input  logic              out_tready,
  output logic              busy,
  output logic              done,
  output logic              deadlock,
  output logic [NF_W-1:0]   frames_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] last_frame_cycles
);

  logic [1:0]        rst_sync_reg;
  logic              rst_n_int;
  state_t            state_reg, state_next;
  logic [NF_W-1:0]   nf_reg, nf_next;
  logic [WDOG_W-1:0] lim_reg, lim_next;
  logic [NF_W-1:0]   frames_done_reg, frames_done_next;
  logic [NF_W-1:0]   frames_inc;
  logic              done_reg, done_next;
  logic              accept_start;
  logic              frame_done_ev;
  logic              progress;
  logic              wdog_expired;

  // Reset asserts immediately and releases two edges after ap_rst_n rises.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end
  assign rst_n_int = rst_sync_reg[1];

  assign progress = (in_tvalid && in_tready) || (out_tvalid && out_tready) ||
                    kern_ap_done || kern_ap_ready;

  assign busy          = (state_reg == START) || (state_reg == RUN);
  assign kern_ap_start = (state_reg == START);
  assign deadlock      = (state_reg == FAULT);
  assign done          = done_reg;
  assign frames_done   = frames_done_reg;

  bgr_wdog #(
    .W(WDOG_W)
  ) u_wdog (
    .ap_clk  (ap_clk),
    .rst_n   (rst_n_int),
    .clear   (accept_start),
    .progress(progress),
    .enable  (busy),
    .limit   (lim_reg),
    .expired (wdog_expired)
  );

  // Sequencer next state; abort beats watchdog, watchdog beats handshakes.
  always_comb begin
    state_next       = state_reg;
    nf_next          = nf_reg;
    lim_next         = lim_reg;
    frames_done_next = frames_done_reg;
    done_next        = 1'b0;
    accept_start     = 1'b0;
    frame_done_ev    = 1'b0;
    frames_inc       = frames_done_reg + NF_W'(1);
    case (state_reg)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          if (cfg_num_frames != '0) begin
            state_next       = START;
            accept_start     = 1'b1;
            nf_next          = cfg_num_frames;
            lim_next         = cfg_wdog_limit;
            frames_done_next = '0;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      START: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (wdog_expired) begin
          state_next = FAULT;
        end else if (kern_ap_ready) begin
          if (kern_ap_done) begin
            frame_done_ev = 1'b1;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end else if (wdog_expired) begin
          state_next = FAULT;
        end else if (kern_ap_done) begin
          frame_done_ev = 1'b1;
        end
      end
      FAULT: begin
        if (cfg_abort) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // A completed frame either finishes the run or launches the next frame.
    if (frame_done_ev) begin
      frames_done_next = frames_inc;
      if (frames_inc == nf_reg) begin
        state_next = IDLE;
        done_next  = 1'b1;
      end else begin
        state_next = START;
      end
    end
  end

  // Sequencer and configuration registers.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_reg       <= IDLE;
      nf_reg          <= '0;
      lim_reg         <= '0;
      frames_done_reg <= '0;
      done_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      nf_reg          <= nf_next;
      lim_reg         <= lim_next;
      frames_done_reg <= frames_done_next;
      done_reg        <= done_next;
    end
  end

`ifdef BGR_CTRL_PERF_EN
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [PERF_W-1:0] stall_reg;
  logic [PERF_W-1:0] frame_cyc_reg;
  logic [PERF_W-1:0] last_frame_reg;
  logic              new_frame;
  logic              stall_ev;

  // A frame begins whenever START is (re)entered, including back-to-back frames.
  assign new_frame = (state_next == START) && ((state_reg != START) || frame_done_ev);
  assign stall_ev  = (state_reg == RUN) &&
                     ((in_tvalid && !in_tready) || (out_tvalid && !out_tready));

  // Stall count, running frame length and captured length of the last frame.
  always_ff @(posedge ap_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      stall_reg      <= '0;
      frame_cyc_reg  <= '0;
      last_frame_reg <= '0;
    end else begin
      if (accept_start) begin
        stall_reg <= '0;
      end else if (stall_ev) begin
        stall_reg <= PERF_W'(sat_inc(SAT_W'(stall_reg), SAT_W'(PERF_MAX)));
      end
      if (new_frame) begin
        frame_cyc_reg <= PERF_W'(1);
      end else if (busy) begin
        frame_cyc_reg <= PERF_W'(sat_inc(SAT_W'(frame_cyc_reg), SAT_W'(PERF_MAX)));
      end
      if (frame_done_ev) begin
        last_frame_reg <= frame_cyc_reg;
      end
    end
  end

  assign stall_cycles      = stall_reg;
  assign last_frame_cycles = last_frame_reg;
`else
  assign stall_cycles      = '0;
  assign last_frame_cycles = '0;
`endif

endmodule
